// File: rtl/ct_ebiu_cawt_ctrl.sv
// CA write table controller: allocates entries to non-cacheable writes, retires
// them on write responses, holds off colliding reads and drains on sync.
module ct_ebiu_cawt_ctrl #(
   parameter int ENTRY_NUM = 8,
   parameter int IDW       = 3,
   parameter int CNTW      = 4
) (
   input  logic                 forever_cpuclk,
   input  logic                 cpurst,
   input  logic                 aw_vld,
   input  logic [7:0]           aw_idx,
   output logic                 aw_ready,
   output logic [IDW-1:0]       aw_id,
   output logic [ENTRY_NUM-1:0] cawt_create_en,
   output logic [ENTRY_NUM-1:0] cawt_create_dp_en,
   input  logic                 b_vld,
   input  logic [IDW-1:0]       b_id,
   output logic [ENTRY_NUM-1:0] cawt_pop_en,
   input  logic [ENTRY_NUM-1:0] ca_rd_addr_hit_cawt,
   input  logic                 ar_vld,
   input  logic [7:0]           ar_idx,
   output logic                 ar_stall,
   input  logic                 sync_req,
   output logic                 sync_ack,
   output logic                 cawt_full,
   output logic                 cawt_empty,
   output logic [CNTW-1:0]      cawt_cnt,
   output logic                 b_err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_DRAIN = 2'd1,
      ST_ACK   = 2'd2
   } state_t;

   state_t                 state_q;
   logic [ENTRY_NUM-1:0]   vld_q, vld_d;
   logic [CNTW-1:0]        cnt_q, cnt_d;
   logic                   b_err_q;
   logic                   sync_ack_q;

   logic                   sel_found;
   logic [IDW-1:0]         sel_id;
   logic                   pop_valid;
   logic [ENTRY_NUM-1:0]   create_oh;
   logic [ENTRY_NUM-1:0]   pop_oh;

   // Lowest-index free entry wins; scanning downward lets the last hit stick.
   always_comb begin
      sel_found = 1'b0;
      sel_id    = '0;
      for (int i = ENTRY_NUM - 1; i >= 0; i--) begin
         if (!vld_q[i]) begin
            sel_found = 1'b1;
            sel_id    = IDW'(i);
         end
      end
   end

   // Allocation is gated by reset so nothing is granted while the table is being cleared.
   assign aw_ready  = ~cpurst & aw_vld & sel_found & (state_q == ST_IDLE) & ~sync_req;
   assign create_oh = aw_ready ? ({{(ENTRY_NUM-1){1'b0}}, 1'b1} << sel_id) : '0;

   // A response for an entry that is not valid is reported, never popped.
   assign pop_valid = b_vld & vld_q[b_id];
   assign pop_oh    = pop_valid ? ({{(ENTRY_NUM-1){1'b0}}, 1'b1} << b_id) : '0;

   assign vld_d = (vld_q | create_oh) & ~pop_oh;
   assign cnt_d = cnt_q + {{(CNTW-1){1'b0}}, aw_ready} - {{(CNTW-1){1'b0}}, pop_valid};

   assign ar_stall = ar_vld & ((|(ca_rd_addr_hit_cawt & vld_q & ~pop_oh)) |
                               (aw_ready & (aw_idx == ar_idx)));

   always_ff @(posedge forever_cpuclk or posedge cpurst) begin
      if (cpurst) begin
         state_q    <= ST_IDLE;
         vld_q      <= '0;
         cnt_q      <= '0;
         b_err_q    <= 1'b0;
         sync_ack_q <= 1'b0;
      end else begin
         vld_q      <= vld_d;
         cnt_q      <= cnt_d;
         b_err_q    <= b_vld & ~vld_q[b_id];
         sync_ack_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (sync_req) state_q <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (cnt_q == '0) begin
                  state_q    <= ST_ACK;
                  sync_ack_q <= 1'b1;
               end
            end
            ST_ACK:  state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign aw_id             = sel_id;
   assign cawt_create_en    = create_oh;
   assign cawt_create_dp_en = create_oh;
   assign cawt_pop_en       = pop_oh;
   assign sync_ack          = sync_ack_q;
   assign cawt_full         = &vld_q;
   assign cawt_empty        = ~|vld_q;
   assign cawt_cnt          = cnt_q;
   assign b_err             = b_err_q;

endmodule

// File: tb/tb_ct_ebiu_cawt_ctrl.sv
// Scoreboard bench for the CA write table controller: a behavioural table model
// predicts every cycle's outputs, a separate monitor compares them against the DUT.
module tb_ct_ebiu_cawt_ctrl;

   logic       clk = 1'b0;
   logic       cpurst;
   logic       aw_vld;
   logic [7:0] aw_idx;
   logic       aw_ready;
   logic [2:0] aw_id;
   logic [7:0] cawt_create_en, cawt_create_dp_en, cawt_pop_en, ca_rd_addr_hit_cawt;
   logic       b_vld;
   logic [2:0] b_id;
   logic       ar_vld;
   logic [7:0] ar_idx;
   logic       ar_stall, sync_req, sync_ack, cawt_full, cawt_empty, b_err;
   logic [3:0] cawt_cnt;

   always #5 clk = ~clk;

   ct_ebiu_cawt_ctrl #(.ENTRY_NUM(8), .IDW(3), .CNTW(4)) dut (
      .forever_cpuclk      (clk),
      .cpurst              (cpurst),
      .aw_vld              (aw_vld),
      .aw_idx              (aw_idx),
      .aw_ready            (aw_ready),
      .aw_id               (aw_id),
      .cawt_create_en      (cawt_create_en),
      .cawt_create_dp_en   (cawt_create_dp_en),
      .b_vld               (b_vld),
      .b_id                (b_id),
      .cawt_pop_en         (cawt_pop_en),
      .ca_rd_addr_hit_cawt (ca_rd_addr_hit_cawt),
      .ar_vld              (ar_vld),
      .ar_idx              (ar_idx),
      .ar_stall            (ar_stall),
      .sync_req            (sync_req),
      .sync_ack            (sync_ack),
      .cawt_full           (cawt_full),
      .cawt_empty          (cawt_empty),
      .cawt_cnt            (cawt_cnt),
      .b_err               (b_err)
   );

   typedef struct {
      logic       aw_ready;
      logic [2:0] aw_id;
      logic [7:0] create;
      logic [7:0] pop;
      logic       ar_stall;
      logic       sync_ack;
      logic       full;
      logic       empty;
      logic [3:0] cnt;
      logic       b_err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   bit   done   = 0;

   // Reference model: the table as a set of valid entries holding a line index,
   // plus the sync sequencer as a phase number (0 idle, 1 draining, 2 acknowledging).
   bit       mdl_vld[8];
   bit [7:0] mdl_idx[8];
   int       mdl_phase;
   bit       mdl_berr;
   bit [7:0] hit_junk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic clr_in();
      aw_vld = 0; aw_idx = 0; b_vld = 0; b_id = 0; ar_vld = 0; ar_idx = 0;
      sync_req = 0; hit_junk = 0;
   endtask

   // Predict this cycle's outputs from the current inputs, queue them, advance the model.
   task automatic step();
      exp_t e;
      int   sel, cnt;
      bit   pv, hit_live;
      if (cpurst) begin
         foreach (mdl_vld[i]) mdl_vld[i] = 0;
         mdl_phase = 0;
         mdl_berr  = 0;
      end
      sel = -1; cnt = 0;
      for (int i = 0; i < 8; i++) begin
         if (mdl_vld[i]) cnt++;
         else if (sel < 0) sel = i;
      end
      for (int i = 0; i < 8; i++)
         ca_rd_addr_hit_cawt[i] = mdl_vld[i] ? (mdl_idx[i] == ar_idx) : hit_junk[i];
      e.aw_ready = !cpurst && aw_vld && (sel >= 0) && (mdl_phase == 0) && !sync_req;
      e.aw_id    = e.aw_ready ? 3'(sel) : 3'd0;
      e.create   = e.aw_ready ? 8'(1 << sel) : 8'd0;
      pv         = b_vld && mdl_vld[b_id];
      e.pop      = pv ? 8'(1 << b_id) : 8'd0;
      hit_live   = 0;
      for (int i = 0; i < 8; i++)
         if (mdl_vld[i] && mdl_idx[i] == ar_idx && !(pv && b_id == 3'(i))) hit_live = 1;
      e.ar_stall = ar_vld && (hit_live || (e.aw_ready && aw_idx == ar_idx));
      e.sync_ack = (mdl_phase == 2);
      e.b_err    = mdl_berr;
      e.cnt      = 4'(cnt);
      e.full     = (cnt == 8);
      e.empty    = (cnt == 0);
      exp_q.push_back(e);
      if (!cpurst) begin
         mdl_berr = b_vld && !mdl_vld[b_id];
         case (mdl_phase)
            0: mdl_phase = sync_req ? 1 : 0;
            1: mdl_phase = (cnt == 0) ? 2 : 1;
            default: mdl_phase = 0;
         endcase
         if (pv) mdl_vld[b_id] = 0;
         if (e.aw_ready) begin
            mdl_vld[sel] = 1;
            mdl_idx[sel] = aw_idx;
         end
      end
      @(negedge clk);
   endtask

   task automatic write(input logic [7:0] idx);
      clr_in(); aw_vld = 1; aw_idx = idx; step();
   endtask

   task automatic do_reset(input int n);
      clr_in(); cpurst = 1;
      for (int i = 0; i < n; i++) step();
      cpurst = 0;
   endtask

   // Monitor: every cycle the DUT presents its outputs, pop the prediction and compare.
   initial begin
      exp_t e;
      while (!done) begin
         @(negedge clk);
         #2;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("aw_ready", aw_ready, e.aw_ready);
            if (e.aw_ready) chk("aw_id", aw_id, e.aw_id);
            chk("create_en", cawt_create_en, e.create);
            chk("create_dp_en", cawt_create_dp_en, e.create);
            chk("pop_en", cawt_pop_en, e.pop);
            chk("ar_stall", ar_stall, e.ar_stall);
            chk("sync_ack", sync_ack, e.sync_ack);
            chk("full", cawt_full, e.full);
            chk("empty", cawt_empty, e.empty);
            chk("cnt", cawt_cnt, e.cnt);
            chk("b_err", b_err, e.b_err);
         end
      end
   end

   initial begin
      clr_in();
      cpurst = 1;
      @(negedge clk);
      do_reset(3);

      $display("phase: fill table");
      for (int i = 0; i < 9; i++) write(8'h10 + 8'(i));

      $display("phase: pop and create same cycle");
      clr_in(); aw_vld = 1; aw_idx = 8'h55; b_vld = 1; b_id = 3; step();
      write(8'h56);
      clr_in(); step();

      $display("phase: read hazard");
      do_reset(1);
      write(8'h23); write(8'h24); write(8'h25);
      clr_in(); ar_vld = 1; ar_idx = 8'h25; step();
      clr_in(); ar_vld = 1; ar_idx = 8'h25; b_vld = 1; b_id = 2; step();
      clr_in(); ar_vld = 1; ar_idx = 8'h40; aw_vld = 1; aw_idx = 8'h40; step();
      clr_in(); ar_vld = 1; ar_idx = 8'h41; aw_vld = 1; aw_idx = 8'h40; step();

      $display("phase: sync drain");
      do_reset(1);
      write(8'h01); write(8'h02); write(8'h03);
      clr_in(); sync_req = 1; aw_vld = 1; aw_idx = 8'h04; step();
      for (int i = 0; i < 3; i++) begin
         clr_in(); b_vld = 1; b_id = 3'(i); aw_vld = 1; step();
      end
      for (int i = 0; i < 4; i++) begin clr_in(); step(); end
      clr_in(); sync_req = 1; step(); step(); step();
      clr_in(); step(); step();

      $display("phase: retire invalid entry");
      do_reset(1);
      clr_in(); b_vld = 1; b_id = 5; step();
      clr_in(); step(); step();

      $display("phase: reset mid-operation");
      for (int i = 0; i < 4; i++) write(8'h60 + 8'(i));
      clr_in(); cpurst = 1; aw_vld = 1; step();
      cpurst = 0;
      clr_in(); b_vld = 1; b_id = 1; step();
      write(8'h70);
      clr_in(); step();

      $display("phase: random traffic");
      for (int n = 0; n < 2000; n++) begin
         cpurst = ($urandom_range(0, 199) == 0);
         aw_vld = 1'($urandom_range(0, 1));
         aw_idx = 8'($urandom_range(0, 15));
         b_vld  = ($urandom_range(0, 2) != 0);
         b_id   = 3'($urandom_range(0, 7));
         if (!sync_req) sync_req = ($urandom_range(0, 39) == 0);
         else           sync_req = ($urandom_range(0, 3) != 0);
         ar_vld   = 1'($urandom_range(0, 1));
         ar_idx   = $urandom_range(0, 1) ? aw_idx : 8'($urandom_range(0, 15));
         hit_junk = 8'($urandom);
         step();
      end
      cpurst = 0;
      clr_in(); step(); step();

      @(negedge clk); @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      done = 1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
